il1_data_ram: RTL and testbench
===============================

Name: il1_data_ram

Overview:
- Parametrised successor to the single-port instruction-cache data RAM.
- Multi-way, line-organised data array with a registered read port.
- Built-in refill sequencer writes a whole cache line, word by word, from the L2/memory side using a valid/ready handshake.
- Sits between IF-stage tag/hit logic (read side) and the L1 miss handler (refill side).

Parameters:
DATA_W, 32, word width in bits
INDEX_W, 8, set index width; sets per way = 2**INDEX_W
WORDS_PER_LINE, 4, words per line; power of 2, >= 2; OFF_W = $clog2(WORDS_PER_LINE)
WAYS, 2, number of ways; power of 2, >= 1; WAY_W = max(1, $clog2(WAYS))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rd_en  in  1  read request
rd_way  in  WAY_W  way to read
rd_index  in  INDEX_W  set to read
rd_offset  in  OFF_W  word within line
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  rd_data valid (rd_en delayed one cycle)
fill_start  in  1  begin refill of a line (accepted only in IDLE)
fill_way  in  WAY_W  target way, sampled on an accepted fill_start
fill_index  in  INDEX_W  target set, sampled on an accepted fill_start
fill_wvalid  in  1  refill word valid
fill_wdata  in  DATA_W  refill word
fill_wready  out  1  sequencer ready for a word
fill_busy  out  1  refill in progress (state != IDLE)
fill_done  out  1  one-cycle pulse after the last word is written
parity_err  out  1  only with ICRAM_PARITY_EN (see below)

Behaviour:
- Storage: WAYS x 2**INDEX_W x WORDS_PER_LINE words of DATA_W. The array is not reset; contents are X until written.
- Read path:
  - rd_en at edge N -> rd_data and rd_valid at edge N+1 (1-cycle latency).
  - rd_data holds its last value when rd_en = 0; rd_valid = 0.
  - Reads are permitted in every FSM state.
- Collision bypass: if a refill write and an rd_en target the same {way, index, offset} in the same cycle, rd_data returns the new fill_wdata (write-first).
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - fill_wready = 0.
    - On fill_start = 1, latch fill_way/fill_index, clear word counter cnt, go to FILL.
  - FILL:
    - fill_wready = 1.
    - On each fill_wvalid & fill_wready, write fill_wdata to {way, index, cnt}, then cnt++.
    - When that handshake occurs with cnt == WORDS_PER_LINE-1, go to DONE.
    - fill_wvalid = 0 stalls; cnt holds and no write occurs.
  - DONE:
    - fill_done = 1 for exactly this cycle; fill_wready = 0.
    - Unconditionally return to IDLE next cycle.
- fill_start while fill_busy = 1 is ignored; latched way/index are unaffected.
- Back-to-back refills: fill_start is first accepted in the IDLE cycle following DONE. Minimum refill occupancy is WORDS_PER_LINE + 2 cycles.
- cnt wraps only by leaving FILL; it never exceeds WORDS_PER_LINE-1.
- Reset values: state = IDLE, cnt = 0, rd_valid = 0, rd_data = 0, fill_wready = 0, fill_busy = 0, fill_done = 0, parity_err = 0.
- Reset mid-refill: FSM returns to IDLE the following cycle. Words already written stay in the array. No fill_done is issued; the miss handler must restart the line.
- rst has priority over all inputs in the same cycle; rd_valid is forced to 0.

Optional Feature:
- ICRAM_PARITY_EN defined:
  - Each stored word carries one extra even-parity bit, computed from fill_wdata on write.
  - On a read, parity is checked. parity_err is asserted alongside rd_valid (same cycle) when the stored bit mismatches.
  - Bypassed reads never flag an error.
- ICRAM_PARITY_EN undefined:
  - No parity storage or logic.
  - parity_err port exists and is tied to 0.

Test Plan:
- Reset, then idle 3 cycles -> fill_busy = 0, fill_wready = 0, fill_done = 0, rd_valid = 0, rd_data = 0.
- fill_start (way 1, index 0x05), then words 0xA0..0xA3 back-to-back -> fill_done pulses exactly 5 cycles after the start edge. Reads of way 1, index 5, offsets 0..3 return 0xA0..0xA3, each one cycle after rd_en.
- Refill with fill_wvalid gapped (1,0,0,1,1,0,1) -> exactly 4 writes at offsets 0..3, no write in gap cycles, fill_done after the 4th handshake only.
- rd_en at way 0, index 0x10, offset 2 in the same cycle as the fill handshake writing 0xDEAD_BEEF there -> rd_data = 0xDEAD_BEEF next cycle (bypass).
- fill_start held high through an entire refill, plus rst asserted after 2 words of a second refill -> first line unaffected by repeated starts. After reset: IDLE, no fill_done, words 0..1 of the second line readable.
- (ICRAM_PARITY_EN) Force-flip one stored bit via backdoor, then read that word -> parity_err = 1 with rd_valid; an unflipped word reads with parity_err = 0.

Source files
------------

// File: rtl/il1_data_ram.sv
// il1_data_ram
// Multi-way, line-organised instruction-cache data array with a registered
// read port and a built-in refill sequencer that writes one whole line, word
// by word, over a valid/ready handshake from the L2/memory side.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   rd_en               read request
//   rd_way/index/offset word address for the read
//   rd_data             registered read data (holds when rd_en = 0)
//   rd_valid            rd_en delayed by one cycle
//   fill_start          begin a line refill (accepted only while idle)
//   fill_way/index      target line, sampled on an accepted fill_start
//   fill_wvalid/wdata   refill word from the memory side
//   fill_wready         sequencer ready for a refill word
//   fill_busy           refill in progress
//   fill_done           one-cycle pulse after the last word is written
//   parity_err          stored-word parity mismatch on a read
//
// Optional feature macro: ICRAM_PARITY_EN
//   Defined   : each word stores an extra even-parity bit, checked on reads.
//   Undefined : no parity storage; parity_err is tied to 0.
module il1_data_ram #(
  parameter int DATA_W         = 32,
  parameter int INDEX_W        = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int WAYS           = 2,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [WAY_W-1:0]   rd_way,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [OFF_W-1:0]   rd_offset,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  input  logic               fill_start,
  input  logic [WAY_W-1:0]   fill_way,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic               fill_wvalid,
  input  logic [DATA_W-1:0]  fill_wdata,
  output logic               fill_wready,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               parity_err
);

  localparam int ADDR_W = WAY_W + INDEX_W + OFF_W;
  localparam int DEPTH  = WAYS * (2 ** INDEX_W) * WORDS_PER_LINE;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);

`ifdef ICRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q;
  logic [WAY_W-1:0]   way_q;
  logic [INDEX_W-1:0] index_q;
  logic               wr_en;
  logic               bypass;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [MEM_W-1:0]   store_word;
  logic [MEM_W-1:0]   rd_word;

  logic [MEM_W-1:0] mem [0:DEPTH-1];

  // With a single way the way field is forced to zero so every address
  // stays inside the array.
  function automatic logic [ADDR_W-1:0] make_addr(input logic [WAY_W-1:0]   way,
                                                  input logic [INDEX_W-1:0] index,
                                                  input logic [OFF_W-1:0]   off);
    logic [WAY_W-1:0] w;
    w = (WAYS > 1) ? way : '0;
    return {w, index, off};
  endfunction

  assign rd_addr = make_addr(rd_way, rd_index, rd_offset);
  assign wr_addr = make_addr(way_q, index_q, cnt_q);
  assign rd_word = mem[rd_addr];

  // A read and a refill write to the same word in one cycle return the new
  // data (write-first).
  assign bypass = wr_en && (rd_addr == wr_addr);

`ifdef ICRAM_PARITY_EN
  assign store_word = {^fill_wdata, fill_wdata};
`else
  assign store_word = fill_wdata;
`endif

  // Next-state and handshake outputs. Reset gates the handshake so that a
  // word presented during reset is never written.
  always_comb begin
    state_d     = state_q;
    fill_wready = 1'b0;
    fill_done   = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) state_d = FILL;
      end
      FILL: begin
        fill_wready = !rst;
        wr_en       = fill_wvalid && !rst;
        if (wr_en && (cnt_q == LAST_OFF)) state_d = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_busy = (state_q != IDLE);

  // Sequencer state, word counter and the latched target line. The target
  // is only captured while idle, so starts during a refill are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && fill_start) begin
        way_q   <= fill_way;
        index_q <= fill_index;
        cnt_q   <= '0;
      end else if (wr_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Data array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= store_word;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= bypass ? fill_wdata : rd_word[DATA_W-1:0];
    end
  end

`ifdef ICRAM_PARITY_EN
  // Stored words have even parity overall; a bypassed read never flags.
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= rd_en && !bypass && (^rd_word);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_il1_data_ram.sv
// Directed self-checking bench for il1_data_ram (default parameters).
module tb_il1_data_ram;

  localparam int DATA_W  = 32;
  localparam int INDEX_W = 8;
  localparam int OFF_W   = 2;
  localparam int WAY_W   = 1;

  logic               clk;
  logic               rst;
  logic               rd_en;
  logic [WAY_W-1:0]   rd_way;
  logic [INDEX_W-1:0] rd_index;
  logic [OFF_W-1:0]   rd_offset;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               fill_start;
  logic [WAY_W-1:0]   fill_way;
  logic [INDEX_W-1:0] fill_index;
  logic               fill_wvalid;
  logic [DATA_W-1:0]  fill_wdata;
  logic               fill_wready;
  logic               fill_busy;
  logic               fill_done;
  logic               parity_err;

  int checks = 0;
  int errors = 0;

  il1_data_ram dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_way      (rd_way),
    .rd_index    (rd_index),
    .rd_offset   (rd_offset),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fill_start  (fill_start),
    .fill_way    (fill_way),
    .fill_index  (fill_index),
    .fill_wvalid (fill_wvalid),
    .fill_wdata  (fill_wdata),
    .fill_wready (fill_wready),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .parity_err  (parity_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; outputs are then stable for sampling 1 ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle read of a word followed by checks of the registered result.
  task automatic readWord(input logic [WAY_W-1:0] way, input logic [INDEX_W-1:0] idx,
                          input logic [OFF_W-1:0] off, input logic [31:0] exp, input string tag);
    rd_way    = way;
    rd_index  = idx;
    rd_offset = off;
    rd_en     = 1'b1;
    applyStimulus();
    rd_en = 1'b0;
    checkOutput({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    checkOutput(tag, rd_data, exp);
  endtask

  // Linear directed sequence.
  initial begin
    logic [6:0] gap_pat;
    int k;

    rst = 1'b1; rd_en = 1'b0; rd_way = '0; rd_index = '0; rd_offset = '0;
    fill_start = 1'b0; fill_way = '0; fill_index = '0; fill_wvalid = 1'b0; fill_wdata = '0;

    // Reset and idle.
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("rst_busy",   {31'd0, fill_busy},   32'd0);
    checkOutput("rst_wready", {31'd0, fill_wready}, 32'd0);
    checkOutput("rst_done",   {31'd0, fill_done},   32'd0);
    checkOutput("rst_valid",  {31'd0, rd_valid},    32'd0);
    checkOutput("rst_data",   rd_data,              32'd0);
    checkOutput("rst_perr",   {31'd0, parity_err},  32'd0);

    // Back-to-back refill of way 1, index 0x05.
    $display("[TB] refill way1 idx05 back-to-back");
    fill_start = 1'b1; fill_way = 1'b1; fill_index = 8'h05;
    applyStimulus();
    fill_start = 1'b0;
    checkOutput("f1_busy",   {31'd0, fill_busy},   32'd1);
    checkOutput("f1_wready", {31'd0, fill_wready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      fill_wvalid = 1'b1;
      fill_wdata  = 32'hA0 + i;
      applyStimulus();
      if (i < 3) checkOutput($sformatf("f1_done_early%0d", i), {31'd0, fill_done}, 32'd0);
    end
    fill_wvalid = 1'b0;
    checkOutput("f1_done",        {31'd0, fill_done},   32'd1);
    checkOutput("f1_done_wready", {31'd0, fill_wready}, 32'd0);
    checkOutput("f1_done_busy",   {31'd0, fill_busy},   32'd1);
    applyStimulus();
    checkOutput("f1_done_clear",  {31'd0, fill_done},   32'd0);
    checkOutput("f1_idle_busy",   {31'd0, fill_busy},   32'd0);

    for (int i = 0; i < 4; i++)
      readWord(1'b1, 8'h05, OFF_W'(i), 32'hA0 + i, $sformatf("f1_rd%0d", i));
    checkOutput("f1_rd_perr", {31'd0, parity_err}, 32'd0);
    applyStimulus();
    checkOutput("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rd_hold_data",  rd_data,           32'hA3);

    // Gapped refill of way 0, index 0x07; gap cycles carry junk data.
    $display("[TB] gapped refill way0 idx07");
    fill_start = 1'b1; fill_way = 1'b0; fill_index = 8'h07;
    applyStimulus();
    fill_start = 1'b0;
    gap_pat = 7'b1011001;
    k = 0;
    for (int p = 0; p < 7; p++) begin
      fill_wvalid = gap_pat[p];
      fill_wdata  = gap_pat[p] ? (32'hB0 + k) : 32'hFFFF_FFFF;
      applyStimulus();
      if (gap_pat[p]) k++;
      checkOutput($sformatf("f2_done_p%0d", p), {31'd0, fill_done}, {31'd0, (k == 4)});
    end
    fill_wvalid = 1'b0;
    applyStimulus();
    for (int i = 0; i < 4; i++)
      readWord(1'b0, 8'h07, OFF_W'(i), 32'hB0 + i, $sformatf("f2_rd%0d", i));

    // Collision bypass on way 0, index 0x10, offset 2.
    $display("[TB] collision bypass way0 idx10 off2");
    fill_start = 1'b1; fill_way = 1'b0; fill_index = 8'h10;
    applyStimulus();
    fill_start = 1'b0;
    fill_wvalid = 1'b1;
    fill_wdata = 32'hC0; applyStimulus();
    fill_wdata = 32'hC1; applyStimulus();
    fill_wdata = 32'hDEAD_BEEF;
    rd_en = 1'b1; rd_way = 1'b0; rd_index = 8'h10; rd_offset = 2'd2;
    applyStimulus();
    rd_en = 1'b0;
    checkOutput("byp_valid", {31'd0, rd_valid},   32'd1);
    checkOutput("byp_data",  rd_data,             32'hDEAD_BEEF);
    checkOutput("byp_perr",  {31'd0, parity_err}, 32'd0);
    fill_wdata = 32'hC3; applyStimulus();
    fill_wvalid = 1'b0;
    applyStimulus();
    readWord(1'b0, 8'h10, 2'd2, 32'hDEAD_BEEF, "byp_stored");
    readWord(1'b0, 8'h10, 2'd3, 32'hC3, "byp_last");

    // fill_start held high through a refill; later starts must not retarget.
    $display("[TB] start held high way1 idx20");
    fill_start = 1'b1; fill_way = 1'b1; fill_index = 8'h20;
    applyStimulus();
    fill_way = 1'b0; fill_index = 8'h21;
    for (int i = 0; i < 4; i++) begin
      fill_wvalid = 1'b1;
      fill_wdata  = 32'hD0 + i;
      applyStimulus();
    end
    fill_start = 1'b0; fill_wvalid = 1'b0;
    checkOutput("held_done", {31'd0, fill_done}, 32'd1);
    applyStimulus();
    for (int i = 0; i < 4; i++)
      readWord(1'b1, 8'h20, OFF_W'(i), 32'hD0 + i, $sformatf("held_rd%0d", i));

    // Second refill interrupted by reset after two words.
    $display("[TB] refill way0 idx30 aborted by reset");
    fill_start = 1'b1; fill_way = 1'b0; fill_index = 8'h30;
    applyStimulus();
    fill_start = 1'b0;
    fill_wvalid = 1'b1;
    fill_wdata = 32'hE0; applyStimulus();
    fill_wdata = 32'hE1; applyStimulus();
    fill_wdata = 32'hE2; rst = 1'b1; rd_en = 1'b1;
    applyStimulus();
    rst = 1'b0; fill_wvalid = 1'b0; rd_en = 1'b0;
    checkOutput("abort_busy",   {31'd0, fill_busy},   32'd0);
    checkOutput("abort_wready", {31'd0, fill_wready}, 32'd0);
    checkOutput("abort_done",   {31'd0, fill_done},   32'd0);
    checkOutput("abort_valid",  {31'd0, rd_valid},    32'd0);
    checkOutput("abort_data",   rd_data,              32'd0);
    applyStimulus();
    checkOutput("abort_done2",  {31'd0, fill_done},   32'd0);
    checkOutput("abort_busy2",  {31'd0, fill_busy},   32'd0);
    readWord(1'b0, 8'h30, 2'd0, 32'hE0, "abort_rd0");
    readWord(1'b0, 8'h30, 2'd1, 32'hE1, "abort_rd1");

`ifdef ICRAM_PARITY_EN
    // Flip one stored bit of way 1, index 0x05, offset 0.
    $display("[TB] parity error injection");
    dut.mem[{1'b1, 8'h05, 2'd0}][0] = ~dut.mem[{1'b1, 8'h05, 2'd0}][0];
    readWord(1'b1, 8'h05, 2'd0, 32'hA1, "par_rd_bad");
    checkOutput("par_err_bad",  {31'd0, parity_err}, 32'd1);
    readWord(1'b1, 8'h05, 2'd1, 32'hA1, "par_rd_good");
    checkOutput("par_err_good", {31'd0, parity_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
